// File: rtl/pc_redirect_controller_pkg.sv
// Shared types and constants for the PC redirect controller.
// The optional counters are enabled by defining REDIRECT_PERF_CNT_EN.
package pc_redirect_controller_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [31:0] PC_ALIGN_MASK = 32'h3;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr & PC_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_redirect_controller_perf_counter.sv
// Redirect and hold-cycle event counters for the PC redirect controller.
// Only instantiated when REDIRECT_PERF_CNT_EN is defined.
module redirect_perf_counter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        redirect_inc,
    input  logic        hold_inc,
    output logic [31:0] redirect_count,
    output logic [31:0] hold_cycle_count
);

    logic [31:0] redirect_cnt_q;
    logic [31:0] redirect_cnt_d;
    logic [31:0] hold_cnt_q;
    logic [31:0] hold_cnt_d;

    // Plain 32-bit adds wrap from all-ones to zero.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        if (redirect_inc) redirect_cnt_d = redirect_cnt_q + 32'd1;
        if (hold_inc)     hold_cnt_d     = hold_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            redirect_cnt_q <= 32'h0;
            hold_cnt_q     <= 32'h0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign redirect_count   = redirect_cnt_q;
    assign hold_cycle_count = hold_cnt_q;

endmodule

// File: rtl/pc_redirect_controller.sv
// Steers the PC mux for EX-stage redirects, holding them across stalls.
// Define REDIRECT_PERF_CNT_EN to add redirect/hold performance counters.
module pc_redirect_controller
    import pc_redirect_controller_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        redirect_req,
    input  logic [31:0] redirect_target,
    input  logic        imem_busy,
    input  logic        stall_in,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        pc_write_en,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        redirect_pending,
`ifdef REDIRECT_PERF_CNT_EN
    output logic        misalign_exc,
    output logic [31:0] redirect_count,
    output logic [31:0] hold_cycle_count
`else
    output logic        misalign_exc
`endif
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] held_q;
    logic [31:0] held_d;

    logic        busy;
    logic        issue;
    logic        sel;
    logic        wen;
    logic        flush;
    logic        pend;
    logic        mis;
    logic [31:0] tgt;

    assign busy = imem_busy | stall_in;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        issue   = 1'b0;
        sel     = 1'b0;
        wen     = 1'b0;
        flush   = 1'b0;
        pend    = 1'b0;
        mis     = 1'b0;
        tgt     = redirect_target;
        unique case (state_q)
            IDLE: begin
                if (!redirect_req) begin
                    wen = ~busy;
                end else if (busy) begin
                    held_d  = redirect_target;
                    state_d = HOLD;
                end else begin
                    issue = 1'b1;
                end
            end
            HOLD: begin
                tgt  = held_q;
                pend = 1'b1;
                if (!busy) begin
                    issue   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        // Alignment is judged at issue so a held target is checked late.
        if (issue) begin
            flush = 1'b1;
            if (is_misaligned(tgt)) begin
                mis = 1'b1;
            end else begin
                sel = 1'b1;
                wen = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            held_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    assign pc_sel           = sel & ~RESET;
    assign pc_target        = RESET ? 32'h0 : tgt;
    assign pc_write_en      = wen & ~RESET;
    assign flush_if_id      = flush & ~RESET;
    assign flush_id_ex      = flush & ~RESET;
    assign redirect_pending = pend & ~RESET;
    assign misalign_exc     = mis & ~RESET;

`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] redirect_cnt;
    logic [31:0] hold_cnt;

    redirect_perf_counter u_perf (
        .CLK              (CLK),
        .RESET            (RESET),
        .redirect_inc     (issue & ~mis),
        .hold_inc         (state_q == HOLD),
        .redirect_count   (redirect_cnt),
        .hold_cycle_count (hold_cnt)
    );

    assign redirect_count   = RESET ? 32'h0 : redirect_cnt;
    assign hold_cycle_count = RESET ? 32'h0 : hold_cnt;
`endif

endmodule
